wb_stage: RTL and testbench

Parametrised writeback stage for the pipelined CPU. It sits between the MEM stage and the register file write port. It accepts one instruction per handshake and selects the result from five sources. Load data arrives from memory after a variable latency, so the stage stalls upstream until it does, then aligns and sign/zero-extends it. Completed instructions are counted, and faulting loads are reported instead of written.

---
 rtl/wb_stage.sv | 148 ++++++++++++++
 tb/tb_wb_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: selects the instruction result, waits for and aligns load
// data, writes the register file, reports faulting loads and counts retirements.
module wb_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64,
  localparam int AL_W   = $clog2(XLEN / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc_imm,
  input  logic [XLEN-1:0]    in_pc4,
  input  logic [2:0]         in_sel,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_reg_wr,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_unsigned,
  input  logic [AL_W-1:0]    in_addr_lo,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_data,
  input  logic               mem_rsp_err,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]    rf_wr_data,
  output logic               exc_load,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  function automatic logic [XLEN-1:0] sel_result(input logic [2:0]      sel,
                                                 input logic [XLEN-1:0] alu,
                                                 input logic [XLEN-1:0] imm,
                                                 input logic [XLEN-1:0] pc_imm,
                                                 input logic [XLEN-1:0] pc4);
    case (sel)
      3'd1:    return imm;
      3'd2:    return pc_imm;
      3'd3:    return pc4;
      default: return alu;
    endcase
  endfunction

  // Mask keeps the loaded width; the complement of the mask carries the extension.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] data,
                                                 input logic [1:0]      size,
                                                 input logic [AL_W-1:0] lo,
                                                 input logic            uns);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sb;
    shifted = data >> {lo, 3'b000};
    case (size)
      2'd0:    begin mask = {XLEN{1'b1}} >> (XLEN - 8);  sb = shifted[7];      end
      2'd1:    begin mask = {XLEN{1'b1}} >> (XLEN - 16); sb = shifted[15];     end
      2'd2:    begin mask = {XLEN{1'b1}} >> (XLEN - 32); sb = shifted[31];     end
      default: begin mask = {XLEN{1'b1}};                sb = shifted[XLEN-1]; end
    endcase
    return (shifted & mask) | ((sb && !uns) ? ~mask : '0);
  endfunction

  function automatic logic load_fault(input logic [1:0] size, input logic [AL_W-1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return (XLEN == 32) || (|lo);
    endcase
  endfunction

  logic [0:0]         state;
  logic [RADDR_W-1:0] pend_rd_p0;
  logic               pend_reg_wr_p0;
  logic [1:0]         pend_size_p0;
  logic               pend_uns_p0;
  logic [AL_W-1:0]    pend_lo_p0;

  logic               accept, is_load, ld_now, ld_resp, ld_done, nl_done;
  logic               ld_fault, wr_ok, waiting;
  logic [RADDR_W-1:0] cur_rd;
  logic               cur_reg_wr;
  logic [1:0]         cur_size;
  logic               cur_uns;
  logic [AL_W-1:0]    cur_lo;
  logic [XLEN-1:0]    wr_data;

  assign waiting  = (state == ST_WAIT);
  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign is_load  = (in_sel == 3'd4);
  assign nl_done  = accept && !is_load;
  assign ld_now   = accept && is_load && mem_rsp_valid;
  assign ld_resp  = waiting && mem_rsp_valid;
  assign ld_done  = ld_now || ld_resp;

  // A waited load completes from its latched attributes, a same-cycle one from the inputs.
  assign cur_rd     = waiting ? pend_rd_p0     : in_rd;
  assign cur_reg_wr = waiting ? pend_reg_wr_p0 : in_reg_wr;
  assign cur_size   = waiting ? pend_size_p0   : in_ld_size;
  assign cur_uns    = waiting ? pend_uns_p0    : in_ld_unsigned;
  assign cur_lo     = waiting ? pend_lo_p0     : in_addr_lo;

  assign ld_fault = load_fault(cur_size, cur_lo) || mem_rsp_err;
  assign wr_ok    = nl_done || (ld_done && !ld_fault);
  assign wr_data  = nl_done ? sel_result(in_sel, in_alu, in_imm, in_pc_imm, in_pc4)
                            : align_load(mem_rsp_data, cur_size, cur_lo, cur_uns);

  // Stage boundary: pending-load attributes captured at accept
  always_ff @(posedge clk) begin
    if (accept && is_load && !mem_rsp_valid) begin
      pend_rd_p0     <= in_rd;
      pend_reg_wr_p0 <= in_reg_wr;
      pend_size_p0   <= in_ld_size;
      pend_uns_p0    <= in_ld_unsigned;
      pend_lo_p0     <= in_addr_lo;
    end
  end

  // Stage boundary: register-file write port, exception pulse and retire count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      exc_load   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (accept && is_load && !mem_rsp_valid)
        state <= ST_WAIT;
      else if (ld_resp)
        state <= ST_IDLE;
      rf_wr_en <= wr_ok && cur_reg_wr && (|cur_rd);
      exc_load <= ld_done && ld_fault;
      if (wr_ok) begin
        rf_wr_addr <= cur_rd;
        rf_wr_data <= wr_data;
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit (4-bit counter) and a 64-bit instance share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_alu = '0, in_imm = '0, in_pc_imm = '0, in_pc4 = '0;
  logic [2:0]  in_sel = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_wr = 1'b0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic [2:0]  in_addr_lo = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;

  logic        rdy32, en32, exc32;
  logic [4:0]  addr32;
  logic [31:0] data32;
  logic [3:0]  cnt32;
  logic        rdy64, en64, exc64;
  logic [4:0]  addr64;
  logic [63:0] data64;
  logic [63:0] cnt64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .in_alu(in_alu[31:0]), .in_imm(in_imm[31:0]), .in_pc_imm(in_pc_imm[31:0]),
    .in_pc4(in_pc4[31:0]), .in_sel(in_sel), .in_rd(in_rd), .in_reg_wr(in_reg_wr),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo[1:0]),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data[31:0]), .mem_rsp_err(mem_rsp_err),
    .rf_wr_en(en32), .rf_wr_addr(addr32), .rf_wr_data(data32), .exc_load(exc32),
    .retire_cnt(cnt32));

  wb_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .in_alu(in_alu), .in_imm(in_imm), .in_pc_imm(in_pc_imm), .in_pc4(in_pc4),
    .in_sel(in_sel), .in_rd(in_rd), .in_reg_wr(in_reg_wr),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .rf_wr_en(en64), .rf_wr_addr(addr64), .rf_wr_data(data64), .exc_load(exc64),
    .retire_cnt(cnt64));

  // Reference model state; index 0 is the 32-bit instance, 1 the 64-bit one.
  bit          m_pend;
  logic [4:0]  p_rd;
  bit          p_rw, p_uns;
  int          p_size, p_lo;
  bit          m_en[2], m_exc[2];
  logic [4:0]  m_addr[2];
  logic [63:0] m_data[2], m_cnt[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_load(input int xlen, input logic [63:0] data, input int sz,
                                     input int lo, input bit uns,
                                     output logic [63:0] v, output bit fault);
    logic [63:0] d;
    int nb;
    d = (xlen == 32) ? (data & 64'hFFFF_FFFF) : data;
    nb = 1 << sz;
    fault = (sz == 3 && xlen == 32) || (lo % nb != 0);
    v = d >> (8 * lo);
    if (nb < 8) begin
      v = v % (64'd1 << (8 * nb));
      if (!uns && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * nb));
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
  endfunction

  task automatic commit(input int w, input logic [4:0] rd, input bit rw, input logic [63:0] v);
    m_en[w]   = rw && (rd != 0);
    m_addr[w] = rd;
    m_data[w] = v;
    m_cnt[w]  = (w == 1) ? m_cnt[w] + 1 : (m_cnt[w] + 1) % 16;
  endtask

  task automatic model_reset();
    m_pend = 0;
    for (int w = 0; w < 2; w++) begin
      m_en[w] = 0; m_exc[w] = 0; m_addr[w] = '0; m_data[w] = '0; m_cnt[w] = '0;
    end
  endtask

  task automatic model_step();
    bit acc, f, uns, rw;
    int sz, lo;
    logic [4:0] rd;
    logic [63:0] res, v;
    acc = in_valid && !m_pend;
    for (int w = 0; w < 2; w++) begin m_en[w] = 0; m_exc[w] = 0; end
    if (acc && in_sel != 3'd4) begin
      case (in_sel)
        3'd1: res = in_imm;
        3'd2: res = in_pc_imm;
        3'd3: res = in_pc4;
        default: res = in_alu;
      endcase
      commit(0, in_rd, in_reg_wr, res & 64'hFFFF_FFFF);
      commit(1, in_rd, in_reg_wr, res);
    end else if (mem_rsp_valid && (m_pend || (acc && in_sel == 3'd4))) begin
      if (m_pend) begin rd = p_rd; rw = p_rw; sz = p_size; uns = p_uns; lo = p_lo; end
      else begin rd = in_rd; rw = in_reg_wr; sz = int'(in_ld_size); uns = in_ld_unsigned; lo = int'(in_addr_lo); end
      for (int w = 0; w < 2; w++) begin
        model_load(w == 1 ? 64 : 32, mem_rsp_data, sz, w == 1 ? lo : lo % 4, uns, v, f);
        if (f || mem_rsp_err) m_exc[w] = 1;
        else commit(w, rd, rw, v);
      end
    end
    if (acc && in_sel == 3'd4 && !mem_rsp_valid) begin
      m_pend = 1; p_rd = in_rd; p_rw = in_reg_wr; p_size = int'(in_ld_size);
      p_uns = in_ld_unsigned; p_lo = int'(in_addr_lo);
    end else if (m_pend && mem_rsp_valid) begin
      m_pend = 0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".rdy32"}, rdy32, !m_pend);
    chk({ph, ".rdy64"}, rdy64, !m_pend);
    chk({ph, ".en32"}, en32, m_en[0]);
    chk({ph, ".en64"}, en64, m_en[1]);
    chk({ph, ".exc32"}, exc32, m_exc[0]);
    chk({ph, ".exc64"}, exc64, m_exc[1]);
    chk({ph, ".addr32"}, addr32, m_addr[0]);
    chk({ph, ".addr64"}, addr64, m_addr[1]);
    chk({ph, ".data32"}, data32, m_data[0]);
    chk({ph, ".data64"}, data64, m_data[1]);
    chk({ph, ".cnt32"}, cnt32, m_cnt[0]);
    chk({ph, ".cnt64"}, cnt64, m_cnt[1]);
  endtask

  task automatic step(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_in();
    in_valid = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [4:0] rd, input bit rw);
    in_valid = 1; in_sel = sel; in_rd = rd; in_reg_wr = rw;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [1:0] sz, input bit uns, input logic [2:0] lo);
    set_op(3'd4, rd, 1'b1); in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = lo;
  endtask

  task automatic set_rsp(input bit v, input logic [63:0] d, input bit err);
    mem_rsp_valid = v; mem_rsp_data = d; mem_rsp_err = err;
  endtask

  task automatic do_reset(input string ph);
    rst = 1;
    #2;
    model_reset();
    check_all({ph, ".async"});
    @(posedge clk);
    #1;
    rst = 0;
    check_all({ph, ".rel"});
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_all("reset");

    // Back-to-back ALU ops
    in_alu = 64'h11; set_op(3'd0, 5'd3, 1'b1); step("alu1");
    in_alu = 64'h22; set_op(3'd0, 5'd4, 1'b1); step("alu2");
    idle_in(); step("alu_idle");
    chk("alu.cnt_is_2", cnt64, 64'd2);

    // pc+4 source, then the same with rd = x0
    in_pc4 = 64'h104; set_op(3'd3, 5'd1, 1'b1); step("pc4");
    chk("pc4.data", data32, 32'h104);
    set_op(3'd3, 5'd0, 1'b1); step("pc4_x0");
    idle_in(); step("pc4_idle");

    // Signed byte load, three waiting cycles, then unsigned variant
    for (int u = 0; u < 2; u++) begin
      set_ld(5'd7, 2'd0, u[0], 3'd2); set_rsp(0, '0, 0); step("ldb_acc");
      idle_in(); step("ldb_w1"); step("ldb_w2");
      set_rsp(1, 64'h0080_0000, 0); step("ldb_rsp");
      chk("ldb.data32", data32, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      idle_in(); step("ldb_idle");
    end

    // Misaligned half, then errored word
    set_ld(5'd8, 2'd1, 1'b0, 3'd1); step("ldh_acc");
    idle_in(); set_rsp(1, 64'hABCD, 0); step("ldh_rsp");
    chk("ldh.exc32", exc32, 1'b1);
    idle_in(); step("ldh_idle");
    set_ld(5'd9, 2'd2, 1'b0, 3'd0); step("ldw_acc");
    idle_in(); step("ldw_wait");
    set_rsp(1, 64'h5555, 1); step("ldw_err");
    idle_in(); step("ldw_idle");

    // Zero-latency word load
    set_ld(5'd10, 2'd2, 1'b0, 3'd0); set_rsp(1, 64'h1234_5678, 0); step("ld0");
    chk("ld0.data32", data32, 32'h1234_5678);
    idle_in(); step("ld0_idle");

    // Double load: full write on 64-bit, fault on 32-bit
    set_ld(5'd11, 2'd3, 1'b0, 3'd0); set_rsp(1, 64'h8877_6655_4433_2211, 0); step("ldd");
    chk("ldd.data64", data64, 64'h8877_6655_4433_2211);
    idle_in(); step("ldd_idle");

    // Reset while waiting, then a stray response
    set_ld(5'd12, 2'd2, 1'b0, 3'd0); step("rstw_acc");
    idle_in();
    do_reset("rstw");
    set_rsp(1, 64'hDEAD_BEEF, 0); step("rstw_stray");
    idle_in(); step("rstw_idle");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_sel         = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      in_rd          = 5'($urandom_range(0, 31));
      in_reg_wr      = ($urandom_range(0, 7) != 0);
      in_ld_size     = 2'($urandom_range(0, 3));
      in_ld_unsigned = 1'($urandom_range(0, 1));
      in_addr_lo     = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      in_alu         = {$urandom, $urandom};
      in_imm         = {$urandom, $urandom};
      in_pc_imm      = {$urandom, $urandom};
      in_pc4         = {$urandom, $urandom};
      mem_rsp_valid  = ($urandom_range(0, 4) < 2);
      mem_rsp_data   = {$urandom, $urandom};
      mem_rsp_err    = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    idle_in(); step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
